instr_decode_stage: RTL and testbench

Registered, parametrised MIPS instruction decode stage: accepts 32-bit instruction words over a valid/ready handshake, splits them into fields, classifies them (R/I/J), extends the immediate to `XLEN`, and holds the decoded records in a `DEPTH`-entry in-order buffer for the execute stage. It sits between instruction fetch and the register file/ALU control. Unlike a purely combinational field splitter, it provides back-pressure, flush, occupancy and optional illegal-instruction flagging.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/instr_decode_stage_if.sv | 39 +++
 rtl/decode_fields.sv | 60 ++++++
 rtl/instr_decode_stage.sv | 86 ++++++++
 tb/tb_instr_decode_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared opcode/funct constants, instruction class enum and decoded-field
// record used by the decode stage and its field decoder.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    CLASS_R = 2'b00,
    CLASS_I = 2'b01,
    CLASS_J = 2'b10
  } instr_class_e;

  // XLEN-independent part of a decoded record; the stage appends the
  // XLEN-wide immediate to form the stored record.
  typedef struct packed {
    logic [5:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [4:0]   shamt;
    logic [5:0]   funct;
    logic [25:0]  addr;
    instr_class_e cls;
    logic         illegal;
  } decode_fields_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-record bus of the decode stage; master = fetch/execute
// side driving the stage, slave = the stage itself.
interface instr_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_op;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [XLEN-1:0] out_imm;
  logic [25:0]     out_addr;
  logic [1:0]      out_class;
  logic            out_illegal;
  logic [LW-1:0]   level;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm, out_addr, out_class, out_illegal, level
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_funct, out_imm, out_addr, out_class, out_illegal, level
  );

endinterface

// File: rtl/decode_fields.sv
// Combinational MIPS word-to-record decoder: field split, class, immediate
// extension and, with DECODE_ILLEGAL_CHECK_EN defined, illegal flagging.
module decode_fields
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output decode_fields_t  fields,
  output logic [XLEN-1:0] imm
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    fields         = '0;
    fields.op      = op;
    fields.rs      = instr[25:21];
    fields.rt      = instr[20:16];
    fields.rd      = instr[15:11];
    fields.shamt   = instr[10:6];
    fields.funct   = funct;
    fields.addr    = instr[25:0];

    if (op == OP_RTYPE)
      fields.cls = CLASS_R;
    else if (op == OP_J || op == OP_JAL)
      fields.cls = CLASS_J;
    else
      fields.cls = CLASS_I;

`ifdef DECODE_ILLEGAL_CHECK_EN
    case (op)
      OP_RTYPE:
        fields.illegal = !(funct inside {FN_SLL, FN_SRL, FN_JR, [FN_ADD:FN_NOR],
                                         FN_SLT, FN_SLTU});
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
        fields.illegal = 1'b0;
      default:
        fields.illegal = 1'b1;
    endcase
`else
    fields.illegal = 1'b0;
`endif
  end

  // Logical immediates zero-extend; everything else (R/J included) sign-extends.
  always_comb begin
    if (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI})
      imm = XLEN'(instr[15:0]);
    else
      imm = XLEN'(signed'(instr[15:0]));
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered MIPS decode stage: decodes on entry and holds DEPTH decoded records
// in order behind a valid/ready handshake. Optional macro DECODE_ILLEGAL_CHECK_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  instr_decode_stage_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    decode_fields_t  f;
    logic [XLEN-1:0] imm;
  } record_t;

  decode_fields_t  dec_fields;
  logic [XLEN-1:0] dec_imm;
  record_t         mem [DEPTH];
  record_t         last_rec;
  record_t         head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            push;
  logic            pop;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr  (bus.in_instr),
    .fields (dec_fields),
    .imm    (dec_imm)
  );

  assign bus.in_ready  = (level < LW'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // An empty buffer keeps presenting the record most recently popped.
  assign head = (level != '0) ? mem[rd_ptr] : last_rec;

  assign bus.out_op      = head.f.op;
  assign bus.out_rs      = head.f.rs;
  assign bus.out_rt      = head.f.rt;
  assign bus.out_rd      = head.f.rd;
  assign bus.out_shamt   = head.f.shamt;
  assign bus.out_funct   = head.f.funct;
  assign bus.out_imm     = head.imm;
  assign bus.out_addr    = head.f.addr;
  assign bus.out_class   = head.f.cls;
  assign bus.out_illegal = head.f.illegal;
  assign bus.level       = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_rec <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{f: dec_fields, imm: dec_imm};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        last_rec <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed test-plan steps followed
// by randomized traffic checked against a queue-based reference model.
module tb_instr_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    int unsigned op, rs, rt, rd, shamt, funct, imm, addr, cls, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t last_read;

  always #5 clk = ~clk;

  instr_decode_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  instr_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic bit is_legal(input int unsigned op, input int unsigned fn);
    if (op == 0) return (fn == 0 || fn == 2 || fn == 8 || (fn >= 32 && fn <= 39) ||
                         fn == 42 || fn == 43);
    return op inside {2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
  endfunction

  // Reference decode straight from the field arithmetic of the instruction set.
  function automatic exp_t model(input int unsigned w);
    exp_t e;
    int unsigned low;
    e.op    = w / 32'd67108864;
    e.rs    = (w / 32'd2097152) % 32;
    e.rt    = (w / 32'd65536) % 32;
    e.rd    = (w / 32'd2048) % 32;
    e.shamt = (w / 32'd64) % 32;
    e.funct = w % 64;
    e.addr  = w % 32'd67108864;
    low     = w % 65536;
    if (e.op >= 12 && e.op <= 15) e.imm = low;
    else e.imm = (low >= 32768) ? low + 32'hFFFF0000 : low;
    e.cls = (e.op == 0) ? 0 : ((e.op == 2 || e.op == 3) ? 2 : 1);
`ifdef DECODE_ILLEGAL_CHECK_EN
    e.ill = is_legal(e.op, e.funct) ? 0 : 1;
`else
    e.ill = 0;
`endif
    return e;
  endfunction

  function automatic exp_t zero_rec();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    exp_t h;
    h = (q.size() != 0) ? q[0] : last_read;
    checkOutput({tag, ".level"},     64'(bus.level),       64'(q.size()));
    checkOutput({tag, ".in_ready"},  64'(bus.in_ready),    64'(q.size() < DEPTH));
    checkOutput({tag, ".out_valid"}, 64'(bus.out_valid),   64'(q.size() != 0));
    checkOutput({tag, ".op"},        64'(bus.out_op),      64'(h.op));
    checkOutput({tag, ".rs"},        64'(bus.out_rs),      64'(h.rs));
    checkOutput({tag, ".rt"},        64'(bus.out_rt),      64'(h.rt));
    checkOutput({tag, ".rd"},        64'(bus.out_rd),      64'(h.rd));
    checkOutput({tag, ".shamt"},     64'(bus.out_shamt),   64'(h.shamt));
    checkOutput({tag, ".funct"},     64'(bus.out_funct),   64'(h.funct));
    checkOutput({tag, ".imm"},       64'(bus.out_imm),     64'(h.imm));
    checkOutput({tag, ".addr"},      64'(bus.out_addr),    64'(h.addr));
    checkOutput({tag, ".class"},     64'(bus.out_class),   64'(h.cls));
    checkOutput({tag, ".illegal"},   64'(bus.out_illegal), 64'(h.ill));
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input string tag, input bit v, input logic [31:0] w,
                               input bit ordy, input bit fl);
    bit accept, take;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.out_ready = ordy;
    bus.flush     = fl;
    accept = v && (q.size() < DEPTH);
    take   = ordy && (q.size() != 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (take) last_read = q.pop_front();
      if (accept) q.push_back(model(w));
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [31:0] w;
    last_read     = zero_rec();
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    #12;
    checkAll("reset");
    rst_n = 1'b1;

    applyStimulus("rtype", 1, 32'h00221820, 1, 0);
    applyStimulus("addi_sext", 1, 32'h2008FFFF, 1, 0);
    applyStimulus("ori_zext", 1, 32'h3408FFFF, 1, 0);
    applyStimulus("jump", 1, 32'h08100000, 1, 0);
    applyStimulus("drain", 0, 32'h0, 1, 0);

    applyStimulus("bp_pushA", 1, 32'h8C430004, 0, 0);
    applyStimulus("bp_pushB", 1, 32'hAC650008, 0, 0);
    applyStimulus("bp_holdC", 1, 32'h1085FFFE, 0, 0);
    applyStimulus("bp_popA", 1, 32'h1085FFFE, 1, 0);
    applyStimulus("bp_popB_pushC", 1, 32'h1085FFFE, 1, 0);
    applyStimulus("bp_popC", 0, 32'h0, 1, 0);
    applyStimulus("bp_empty", 0, 32'h0, 1, 0);

    applyStimulus("fl_fill1", 1, 32'h24A5007F, 0, 0);
    applyStimulus("fl_fill2", 1, 32'h0085302A, 0, 0);
    applyStimulus("flush", 1, 32'h3C01ABCD, 1, 1);
    applyStimulus("post_flush", 0, 32'h0, 1, 0);

    applyStimulus("illegal", 1, 32'hFC000000, 0, 0);
    applyStimulus("bad_funct", 1, 32'h0000003F, 1, 0);
    applyStimulus("drain2", 0, 32'h0, 1, 0);
    applyStimulus("drain3", 0, 32'h0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[31:26] = 6'h00;
      applyStimulus("random", ($urandom_range(0, 3) != 0), w,
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    applyStimulus("pre_rst1", 1, 32'h2108FFF0, 0, 0);
    applyStimulus("pre_rst2", 1, 32'h0C000123, 0, 0);
    rst_n = 1'b0;
    #2;
    q.delete();
    last_read = zero_rec();
    checkAll("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 1, 32'h3508FFFF, 1, 0);
    applyStimulus("post_rst_drain", 0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
